hyperbus_ctrl: RTL and testbench
================================

# hyperbus_ctrl

Single-word HyperBus memory controller that turns the `hbus_*` request interface (`rrq`/`wrq`, address, 16-bit data, `ready`/`valid`/`busy`) into HyperBus bus cycles. It sits directly downstream of the Wishbone clock-domain FIFO bridge and runs entirely in the `hbus_clk` domain. Per transaction it:
- generates CS#, CK and the 48-bit command/address (CA) phase;
- counts initial latency;
- performs one 16-bit word transfer;
- enforces read-write recovery before accepting the next request.

## Interface
- `LATENCY`, 6: initial latency in device CK cycles (tACC count).
- `RWR`, 4: recovery cycles (`hbus_clk`) with CS# high between transactions.
- `RD_TIMEOUT`, 64: `hbus_clk` cycles allowed in read data phase before abort.
- `hbus_clk` in 1: controller clock; one DQ byte per cycle.
- `hbus_rst` in 1: asynchronous, active-high reset.
- `hbus_adr_i` in 32: word address of request.
- `hbus_dat_i` in 16: write data.
- `hbus_dat_o` out 16: read data, valid while `hbus_valid`=1.
- `hbus_rrq` in 1: read request pulse.
- `hbus_wrq` in 1: write request pulse.
- `hbus_ready` out 1: controller idle, request accepted this cycle.
- `hbus_valid` out 1: one-cycle read-data strobe.
- `hbus_busy` out 1: transaction in progress, including recovery.
- `hbus_err` out 1: one-cycle strobe on read timeout.
- `hb_cs_n` out 1: chip select, active low.
- `hb_ck` out 1: device clock, toggles each `hbus_clk` while active.
- `hb_rst_n` out 1: device reset, equals `~hbus_rst` registered.
- `hb_dq_o` out 8: DQ output.
- `hb_dq_oe` out 1: DQ output enable.
- `hb_dq_i` in 8: DQ input.
- `hb_rwds_o` out 1: RWDS output (write mask).
- `hb_rwds_oe` out 1: RWDS output enable.
- `hb_rwds_i` in 1: RWDS input.

## Operation
- **Reset values:**
  - high: `hb_cs_n`=1, `hbus_ready`=1.
  - low: `hb_ck`, `hb_dq_oe`, `hb_rwds_oe`, `hb_dq_o`, `hb_rwds_o`, `hbus_valid`, `hbus_err`, `hbus_busy`, `hb_rst_n`.
  - zero: `hbus_dat_o`.
  - state: IDLE.
- **Request acceptance:**
  - IDLE only; requests outside IDLE are ignored (not queued).
  - `hbus_wrq` and `hbus_rrq` in the same cycle: write wins, read is dropped.
  - Address and write data are latched on acceptance.
- **CA word:**
  - CA[47] = 1 for read, 0 for write; CA[46] = 0 (memory space); CA[45] = 1 (linear burst).
  - CA[44:16] = adr[31:3]; CA[15:3] = 0; CA[2:0] = adr[2:0].
  - Sent MSB byte first.
- **States:**
  - IDLE: on request go to CS, `hbus_ready`=0, `hbus_busy`=1.
  - CS: `hb_cs_n`=0 for 1 cycle, `hb_ck` held low.
  - CA: 6 cycles. `hb_dq_oe`=1, one CA byte per cycle, `hb_ck` toggles each cycle. `hb_rwds_i` is sampled in the first CA cycle.
  - LAT: 2*`LATENCY` cycles, or 4*`LATENCY` per Configuration. `hb_dq_oe`=0, `hb_ck` toggling.
  - WR: 2 cycles. `hb_dq_oe`=1, `hb_rwds_oe`=1, `hb_rwds_o`=0 (no mask). Byte order: dat[15:8], then dat[7:0].
  - RD: synchronous RWDS edge detect. A byte is captured on each cycle where `hb_rwds_i` differs from its registered value. First byte goes to dat_o[15:8], second to [7:0]. After the second byte, `hbus_valid` pulses with the word on the following cycle, then go to HOLD.
  - RD timeout: if `RD_TIMEOUT` cycles elapse without both bytes, pulse `hbus_err`, no `hbus_valid`, go to HOLD.
  - HOLD: `hb_ck` low, all OE low. 1 cycle, then `hb_cs_n`=1.
  - RECOV: `RWR` cycles, then IDLE with `hbus_ready`=1, `hbus_busy`=0.
- **Async reset mid-transaction:** all outputs return to reset values immediately and the transaction is lost.

## Timing
- Write request accepted at cycle 0:
  - `hb_cs_n` low at 1;
  - CA bytes in cycles 2–7;
  - data in cycles 8+L to 9+L, where L = latency cycles;
  - `hb_cs_n` high at 11+L;
  - `hbus_ready` high at 11+L+`RWR`.
- Read: `hbus_valid` one cycle after the second RWDS edge is detected.
- `hb_ck` always ends low before `hb_cs_n` rises.
- `hb_ck` never toggles while `hb_cs_n`=1.

## Configuration
- `HYPERBUS_VARLAT_EN` defined: latency is 4*`LATENCY` cycles if `hb_rwds_i`=1 when sampled in CA, else 2*`LATENCY`.
- Not defined: fixed latency, always 4*`LATENCY`; `hb_rwds_i` is ignored during CA.

## Test plan
- Reset, then idle 10 cycles -> `hb_cs_n`=1, `hbus_ready`=1, `hb_ck`=0, all OE=0 throughout.
- Write adr=0x0000_1235, dat=0xBEEF, LATENCY=6, macro off -> CA bytes 0x20,0x00,0x02,0x46,0x00,0x05. Then 24 latency cycles, DQ 0xBE then 0xEF with `hb_rwds_o`=0; `hbus_ready` back after HOLD+`RWR`.
- Read adr=0x10, device model returns 0x1234 with RWDS toggling -> first CA byte 0xA0; `hbus_valid`=1 for exactly 1 cycle with `hbus_dat_o`=0x1234.
- Macro on, `hb_rwds_i`=0 during CA -> 12 latency cycles; `hb_rwds_i`=1 during CA -> 24 latency cycles.
- Read with RWDS never toggling -> `hbus_err` pulses at `RD_TIMEOUT`, no `hbus_valid`, `hb_cs_n` returns high.
- Same-cycle `hbus_rrq`+`hbus_wrq` -> write cycle only (CA[47]=0); `hbus_rrq` during LAT is ignored; `hbus_rst` asserted mid-CA -> `hb_cs_n`=1 immediately.

Source files
------------

// File: rtl/hyperbus_ctrl_if.sv
// Request-side (hbus_*) and HyperBus pin-side (hb_*) signals of hyperbus_ctrl.
// The controller uses the slave modport; the requester/device side uses master.
interface hyperbus_ctrl_if;
  logic [31:0] hbus_adr_i;
  logic [15:0] hbus_dat_i;
  logic [15:0] hbus_dat_o;
  logic        hbus_rrq;
  logic        hbus_wrq;
  logic        hbus_ready;
  logic        hbus_valid;
  logic        hbus_busy;
  logic        hbus_err;
  logic        hb_cs_n;
  logic        hb_ck;
  logic        hb_rst_n;
  logic [7:0]  hb_dq_o;
  logic        hb_dq_oe;
  logic [7:0]  hb_dq_i;
  logic        hb_rwds_o;
  logic        hb_rwds_oe;
  logic        hb_rwds_i;

  modport slave (
    input  hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq, hb_dq_i, hb_rwds_i,
    output hbus_dat_o, hbus_ready, hbus_valid, hbus_busy, hbus_err,
           hb_cs_n, hb_ck, hb_rst_n, hb_dq_o, hb_dq_oe, hb_rwds_o, hb_rwds_oe
  );

  modport master (
    output hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq, hb_dq_i, hb_rwds_i,
    input  hbus_dat_o, hbus_ready, hbus_valid, hbus_busy, hbus_err,
           hb_cs_n, hb_ck, hb_rst_n, hb_dq_o, hb_dq_oe, hb_rwds_o, hb_rwds_oe
  );
endinterface

// File: rtl/hyperbus_ctrl.sv
// Single-word HyperBus controller: CS/CA/latency/data/hold/recovery per request.
// Define HYPERBUS_VARLAT_EN for RWDS-selected 2x/4x initial latency (default fixed 4x).
module hyperbus_ctrl #(
  parameter int LATENCY    = 6,
  parameter int RWR        = 4,
  parameter int RD_TIMEOUT = 64
) (
  input  logic           hbus_clk,
  input  logic           hbus_rst,
  hyperbus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CS, S_CA, S_LAT, S_WR, S_RD, S_HOLD, S_RECOV
  } state_t;

  localparam logic [15:0] C_LAT2 = 16'(2 * LATENCY);
  localparam logic [15:0] C_LAT4 = 16'(4 * LATENCY);
  localparam logic [15:0] C_RWR  = 16'(RWR);
  localparam logic [15:0] C_TO   = 16'(RD_TIMEOUT);

  state_t      r_state, w_nxt;
  logic [15:0] r_cnt;
  logic [31:0] r_adr;
  logic [15:0] r_dat;
  logic        r_is_rd;
  logic        r_ck;
  logic        r_valid;
  logic        r_err;
  logic        r_rst_n;
  logic        r_rwds_q;
  logic        r_byte;
  logic [15:0] r_dat_o;

  logic [47:0] w_ca;
  logic [15:0] w_lat;
  logic        w_acc;
  logic        w_edge;
  logic        w_to;
  logic        w_ck_run;
  logic        w_cs_n;
  logic [7:0]  w_dq_o;
  logic        w_dq_oe;
  logic        w_rwds_oe;

  assign w_ca   = {r_is_rd, 1'b0, 1'b1, r_adr[31:3], 13'd0, r_adr[2:0]};
  assign w_acc  = bus.hbus_wrq | bus.hbus_rrq;
  assign w_edge = bus.hb_rwds_i ^ r_rwds_q;

`ifdef HYPERBUS_VARLAT_EN
  logic r_lat_long;

  // Device signals refresh collision on RWDS during the first CA byte.
  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst)                              r_lat_long <= 1'b0;
    else if (r_state == S_CA && r_cnt == 16'd0) r_lat_long <= bus.hb_rwds_i;
  end

  assign w_lat = r_lat_long ? C_LAT4 : C_LAT2;
`else
  assign w_lat = C_LAT4;
`endif

  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_to      = 1'b0;
    w_cs_n    = 1'b0;
    w_dq_o    = 8'd0;
    w_dq_oe   = 1'b0;
    w_rwds_oe = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cs_n = 1'b1;
        if (w_acc) w_nxt = S_CS;
      end
      S_CS: w_nxt = S_CA;
      S_CA: begin
        w_dq_oe = 1'b1;
        case (r_cnt[2:0])
          3'd0:    w_dq_o = w_ca[47:40];
          3'd1:    w_dq_o = w_ca[39:32];
          3'd2:    w_dq_o = w_ca[31:24];
          3'd3:    w_dq_o = w_ca[23:16];
          3'd4:    w_dq_o = w_ca[15:8];
          3'd5:    w_dq_o = w_ca[7:0];
          default: w_dq_o = 8'd0;
        endcase
        if (r_cnt == 16'd5) w_nxt = S_LAT;
      end
      S_LAT: if (r_cnt == w_lat - 16'd1) w_nxt = r_is_rd ? S_RD : S_WR;
      S_WR: begin
        w_dq_oe   = 1'b1;
        w_rwds_oe = 1'b1;
        w_dq_o    = r_cnt[0] ? r_dat[7:0] : r_dat[15:8];
        if (r_cnt == 16'd1) w_nxt = S_HOLD;
      end
      S_RD: begin
        if (w_edge && r_byte) w_nxt = S_HOLD;
        else if (r_cnt == C_TO - 16'd1) begin
          w_to  = 1'b1;
          w_nxt = S_HOLD;
        end
      end
      S_HOLD: w_nxt = S_RECOV;
      S_RECOV: begin
        w_cs_n = 1'b1;
        if (r_cnt == C_RWR - 16'd1) w_nxt = S_IDLE;
      end
      default: begin
        w_cs_n = 1'b1;
        w_nxt  = S_IDLE;
      end
    endcase
  end

  // CK runs only in states that will be active next cycle, so it always starts
  // from low after CS and is forced low in HOLD before CS# rises.
  assign w_ck_run = (w_nxt == S_CA) || (w_nxt == S_LAT) ||
                    (w_nxt == S_WR) || (w_nxt == S_RD);

  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      r_cnt    <= 16'd0;
      r_adr    <= 32'd0;
      r_dat    <= 16'd0;
      r_is_rd  <= 1'b0;
      r_ck     <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_rst_n  <= 1'b0;
      r_rwds_q <= 1'b0;
      r_byte   <= 1'b0;
      r_dat_o  <= 16'd0;
    end else begin
      r_rst_n  <= 1'b1;
      r_rwds_q <= bus.hb_rwds_i;
      r_ck     <= w_ck_run ? ~r_ck : 1'b0;
      r_valid  <= 1'b0;
      r_err    <= w_to;
      r_cnt    <= (w_nxt != r_state || r_state == S_IDLE) ? 16'd0 : r_cnt + 16'd1;
      if (r_state == S_IDLE && w_acc) begin
        r_adr   <= bus.hbus_adr_i;
        r_dat   <= bus.hbus_dat_i;
        r_is_rd <= ~bus.hbus_wrq;
      end
      if (r_state != S_RD) r_byte <= 1'b0;
      else if (w_edge) begin
        if (!r_byte) begin
          r_dat_o[15:8] <= bus.hb_dq_i;
          r_byte        <= 1'b1;
        end else begin
          r_dat_o[7:0]  <= bus.hb_dq_i;
          r_valid       <= 1'b1;
        end
      end
    end
  end

  assign bus.hbus_dat_o = r_dat_o;
  assign bus.hbus_ready = (r_state == S_IDLE);
  assign bus.hbus_busy  = (r_state != S_IDLE);
  assign bus.hbus_valid = r_valid;
  assign bus.hbus_err   = r_err;
  assign bus.hb_cs_n    = w_cs_n;
  assign bus.hb_ck      = r_ck;
  assign bus.hb_rst_n   = r_rst_n;
  assign bus.hb_dq_o    = w_dq_o;
  assign bus.hb_dq_oe   = w_dq_oe;
  assign bus.hb_rwds_o  = 1'b0;
  assign bus.hb_rwds_oe = w_rwds_oe;

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Randomized bench for hyperbus_ctrl: per-cycle bus capture compared against
// a timeline model derived from the transaction rules.
module tb_hyperbus_ctrl;
  localparam int LATENCY    = 6;
  localparam int RWR        = 4;
  localparam int RD_TIMEOUT = 64;
  localparam int MAXC       = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hyperbus_ctrl_if bif();

  hyperbus_ctrl #(.LATENCY(LATENCY), .RWR(RWR), .RD_TIMEOUT(RD_TIMEOUT)) u_dut (
    .hbus_clk(clk),
    .hbus_rst(rst),
    .bus     (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit         s_cs   [MAXC+1];
  bit         s_ck   [MAXC+1];
  bit         s_oe   [MAXC+1];
  bit         s_rwoe [MAXC+1];
  bit         s_rwo  [MAXC+1];
  bit         s_vld  [MAXC+1];
  bit         s_err  [MAXC+1];
  bit         s_rdy  [MAXC+1];
  bit         s_busy [MAXC+1];
  logic [7:0]  s_dq   [MAXC+1];
  logic [15:0] s_dato [MAXC+1];

  task automatic chk(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lat_cyc(input bit rwds_ca);
`ifdef HYPERBUS_VARLAT_EN
    return (rwds_ca ? 4 : 2) * LATENCY;
`else
    return rwds_ca ? 4 * LATENCY : 4 * LATENCY;
`endif
  endfunction

  task automatic idle_chk(input int n, input string tag);
    int viol = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bif.hb_cs_n !== 1'b1 || bif.hb_ck !== 1'b0 || bif.hb_dq_oe !== 1'b0 ||
          bif.hb_rwds_oe !== 1'b0 || bif.hbus_ready !== 1'b1 || bif.hbus_busy !== 1'b0)
        viol++;
    end
    chk(tag, viol, 0);
  endtask

  // d1 < 0: device never drives RWDS edges (read timeout).
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] adr,
                         input logic [15:0] dat, input logic [15:0] word,
                         input int d1, input int d2, input int inj, input bit rwds_ca);
    bit rdop, to;
    int L, e1, e2, w, t_rdy, t_cs_exp, t_cs_obs, viol, nv, tv, ne, te;
    logic [47:0] ca;
    rdop = !wr && rd;
    to   = rdop && (d1 < 0);
    L    = lat_cyc(rwds_ca);
    ca   = (48'(rdop) << 47) | (48'd1 << 45) | (48'(adr >> 3) << 16) | 48'(adr % 8);
    e1   = 8 + L + d1;
    e2   = e1 + 1 + d2;
    w = 0;
    @(negedge clk);
    while (!bif.hbus_ready && w < 100) begin @(negedge clk); w++; end
    chk("pre_ready", bif.hbus_ready, 1);
    bif.hbus_wrq   = wr;
    bif.hbus_rrq   = rd;
    bif.hbus_adr_i = adr;
    bif.hbus_dat_i = dat;
    bif.hb_rwds_i  = 1'b0;
    bif.hb_dq_i    = 8'h00;
    t_rdy = -1;
    for (int t = 1; t <= MAXC; t++) begin
      @(negedge clk);
      s_cs[t] = bif.hb_cs_n;      s_ck[t] = bif.hb_ck;       s_oe[t] = bif.hb_dq_oe;
      s_rwoe[t] = bif.hb_rwds_oe; s_rwo[t] = bif.hb_rwds_o;  s_dq[t] = bif.hb_dq_o;
      s_vld[t] = bif.hbus_valid;  s_err[t] = bif.hbus_err;   s_rdy[t] = bif.hbus_ready;
      s_busy[t] = bif.hbus_busy;  s_dato[t] = bif.hbus_dat_o;
      bif.hbus_wrq = 1'b0;
      bif.hbus_rrq = (t == inj);
      if (t == 2) bif.hb_rwds_i = rwds_ca;
      else if (t == 3) bif.hb_rwds_i = 1'b0;
      if (rdop && !to) begin
        if (t == e1) begin bif.hb_rwds_i = 1'b1; bif.hb_dq_i = word[15:8]; end
        else if (t == e2) begin bif.hb_rwds_i = 1'b0; bif.hb_dq_i = word[7:0]; end
      end
      if (t > 1 && s_rdy[t]) begin t_rdy = t; break; end
    end
    bif.hbus_rrq = 1'b0;
    chk("rdy_seen", (t_rdy > 0), 1);
    if (t_rdy < 0) return;
    chk("cs_start", {s_cs[1], s_busy[1], s_rdy[1], s_ck[1]}, 4'b0100);
    for (int k = 0; k < 6; k++)
      chk("ca_byte", {s_oe[2+k], s_dq[2+k]}, {1'b1, 8'(ca >> (8 * (5 - k)))});
    chk("ck_ca", {s_ck[2], s_ck[3], s_ck[4], s_ck[5], s_ck[6], s_ck[7]}, 6'b101010);
    viol = 0;
    for (int t = 8; t < 8 + L; t++) if (s_oe[t] || s_cs[t]) viol++;
    chk("lat_oe", viol, 0);
    t_cs_exp = wr ? 11 + L : (to ? 9 + L + RD_TIMEOUT : e2 + 2);
    t_cs_obs = 0;
    for (int t = 1; t <= t_rdy; t++) if (s_cs[t] && t_cs_obs == 0) t_cs_obs = t;
    chk("cs_rise", t_cs_obs, t_cs_exp);
    chk("rdy_time", t_rdy, t_cs_exp + RWR);
    viol = 0;
    for (int t = 1; t <= t_rdy; t++) if (s_cs[t] && s_ck[t]) viol++;
    if (t_cs_obs > 1 && s_ck[t_cs_obs-1]) viol++;
    chk("ck_rule", viol, 0);
    if (wr) begin
      chk("wr_d0", {s_oe[8+L], s_rwoe[8+L], s_rwo[8+L], s_dq[8+L]}, {3'b110, dat[15:8]});
      chk("wr_d1", {s_oe[9+L], s_rwoe[9+L], s_rwo[9+L], s_dq[9+L]}, {3'b110, dat[7:0]});
    end
    nv = 0; tv = 0; ne = 0; te = 0;
    for (int t = 1; t <= t_rdy; t++) begin
      if (s_vld[t]) begin nv++; tv = t; end
      if (s_err[t]) begin ne++; te = t; end
    end
    chk("valid_cnt", nv, (rdop && !to) ? 1 : 0);
    chk("err_cnt", ne, to ? 1 : 0);
    if (rdop && !to) begin
      chk("valid_at", tv, e2 + 1);
      chk("rd_data", s_dato[tv], word);
    end
    if (to) chk("err_at", te, 8 + L + RD_TIMEOUT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.hbus_adr_i = '0; bif.hbus_dat_i = '0; bif.hbus_rrq = 1'b0; bif.hbus_wrq = 1'b0;
    bif.hb_dq_i = '0; bif.hb_rwds_i = 1'b0;
    #12;
    chk("rst_vals", {bif.hb_cs_n, bif.hbus_ready, bif.hb_ck, bif.hb_dq_oe, bif.hb_rwds_oe,
                     bif.hb_rwds_o, bif.hbus_valid, bif.hbus_err, bif.hbus_busy, bif.hb_rst_n},
        10'b1100000000);
    chk("rst_data", {bif.hb_dq_o, bif.hbus_dat_o}, 0);
    @(negedge clk); rst = 1'b0;
    idle_chk(10, "idle_after_rst");
    chk("hb_rst_n", bif.hb_rst_n, 1);

    run_txn(1, 0, 32'h0000_1235, 16'hBEEF, 16'h0, 0, 0, 0, 0);
    idle_chk(3, "idle_w");
    run_txn(0, 1, 32'h0000_0010, 16'h0, 16'h1234, 1, 2, 0, 0);
    run_txn(0, 1, $urandom, 16'h0, 16'h0, -1, 0, 0, 0);
    run_txn(1, 1, $urandom, 16'(($urandom)), 16'hAAAA, 0, 0, 0, 0);
    idle_chk(3, "idle_both");
    run_txn(1, 0, $urandom, 16'h5A5A, 16'h0, 0, 0, 12, 0);
    idle_chk(5, "rrq_lat_ignored");
    run_txn(0, 1, $urandom, 16'h0, 16'hC3E1, 0, 0, 10, 0);
    idle_chk(5, "rrq_lat_ignored_rd");
    run_txn(1, 0, $urandom, 16'h1357, 16'h0, 0, 0, 0, 0);
    run_txn(1, 0, $urandom, 16'h2468, 16'h0, 0, 0, 0, 1);
    run_txn(0, 1, $urandom, 16'h0, 16'h9ABC, 0, 0, 0, 1);

    for (int i = 0; i < 16; i++) begin
      bit wr, rd;
      wr = 1'($urandom % 2);
      rd = wr ? 1'($urandom % 2) : 1'b1;
      run_txn(wr, rd, $urandom, 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              ($urandom % 2) ? 9 + int'($urandom_range(0, 9)) : 0, 1'($urandom % 2));
    end

    @(negedge clk);
    bif.hbus_wrq = 1'b1; bif.hbus_adr_i = $urandom;
    @(negedge clk); bif.hbus_wrq = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mid_ca_cs", {bif.hb_cs_n, bif.hb_dq_oe}, 2'b01);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {bif.hb_cs_n, bif.hb_ck, bif.hb_dq_oe, bif.hb_rwds_oe, bif.hbus_busy,
                      bif.hbus_ready, bif.hb_rst_n}, 7'b1000010);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_chk(3, "idle_after_mid_rst");
    chk("hb_rst_n_rel", bif.hb_rst_n, 1);
    run_txn(1, 0, $urandom, 16'hFACE, 16'h0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
